// File: rtl/otter_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IOBUS with a TX FIFO and a drain interrupt.
// Define UART_PARITY_EN to add CTRL PAR_EN/PAR_ODD and a PARITY bit between DATA and STOP.
module otter_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        TX,
  output logic        INTR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            wr_en, push_req, push, pop;
  logic [1:0]      reg_sel;
  logic [15:0]     bauddiv;
  logic            int_en, ovf;
  logic [15:0]     baud_cnt;
  logic            bit_done;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            tx_nxt;
  logic            unused_bits;
`ifdef UART_PARITY_EN
  logic            par_en, par_odd, par_bit;
`endif

  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

  assign RD_HIT   = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = IOBUS_ADDR[3:2];
  assign wr_en    = IOBUS_WR & RD_HIT;
  assign push_req = wr_en && (reg_sel == 2'd0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = (state == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push     = push_req && (!full || pop);
  assign bit_done = (baud_cnt == '0);

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bauddiv <= DEFAULT_DIV;
      int_en  <= 1'b0;
      ovf     <= 1'b0;
`ifdef UART_PARITY_EN
      par_en  <= 1'b0;
      par_odd <= 1'b0;
`endif
    end else begin
      if (push_req && full && !pop) ovf <= 1'b1;
      if (wr_en) begin
        case (reg_sel)
          2'd1: if (IOBUS_OUT[3]) ovf <= 1'b0;
          2'd2: bauddiv <= IOBUS_OUT[15:0];
          2'd3: begin
            int_en  <= IOBUS_OUT[0];
`ifdef UART_PARITY_EN
            par_en  <= IOBUS_OUT[1];
            par_odd <= IOBUS_OUT[2];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = START;
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shift[0];
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
          state_nxt = par_en ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_nxt = par_bit ^ par_odd;
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TX is registered from the state-decoded level, so the line lags the FSM by one clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      TX       <= 1'b1;
      INTR     <= 1'b0;
      baud_cnt <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      TX    <= tx_nxt;
      INTR  <= int_en & empty & (state == IDLE);
      if (pop) begin
        shift    <= mem[rptr];
        baud_cnt <= bauddiv;
        bit_cnt  <= '0;
`ifdef UART_PARITY_EN
        par_bit  <= ^mem[rptr];
`endif
      end else if (state != IDLE) begin
        if (bit_done) begin
          baud_cnt <= bauddiv;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt - 16'd1;
        end
      end
    end
  end

  always_comb begin
    RD_DATA = '0;
    if (RD_HIT) begin
      case (reg_sel)
        2'd1: begin
          RD_DATA[0]    = full;
          RD_DATA[1]    = empty;
          RD_DATA[2]    = (state != IDLE);
          RD_DATA[3]    = ovf;
          RD_DATA[14:8] = 7'(count);
        end
        2'd2: RD_DATA[15:0] = bauddiv;
        2'd3: begin
          RD_DATA[0] = int_en;
`ifdef UART_PARITY_EN
          RD_DATA[1] = par_en;
          RD_DATA[2] = par_odd;
`endif
        end
        default: RD_DATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_uart_tx_mmio.sv
// Directed self-checking bench for otter_uart_tx_mmio; parity checks compile only with UART_PARITY_EN.
module tb_otter_uart_tx_mmio;

  localparam logic [31:0] A_TX = 32'h1100_0100;
  localparam logic [31:0] A_ST = 32'h1100_0104;
  localparam logic [31:0] A_BD = 32'h1100_0108;
  localparam logic [31:0] A_CT = 32'h1100_010C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        wr;
  logic [31:0] rd_data;
  logic        rd_hit, tx, intr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] byte_q[$];
  int         mon_p = 4;
  logic       mon_busy = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_sh = '0;

  otter_uart_tx_mmio #(
    .BASE_ADDR(32'h1100_0100),
    .FIFO_DEPTH(8),
    .DEFAULT_DIV(16'd867)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT(wdata),
    .IOBUS_WR(wr),
    .RD_DATA(rd_data),
    .RD_HIT(rd_hit),
    .TX(tx),
    .INTR(intr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  // Receiver: samples the first negedge of every bit period, LSB first.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy <= 1'b1;
        mon_t    <= 0;
      end
    end else begin
      mon_t <= mon_t + 1;
      if (((mon_t + 1) % mon_p) == 0) begin
        if (((mon_t + 1) / mon_p) <= 8) begin
          mon_sh <= {tx, mon_sh[7:1]};
        end else begin
          byte_q.push_back(mon_sh);
          mon_busy <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
    addr  = 32'h0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0]  frame;
    logic [7:0]  exp_b [10];
    int          waited;
`ifdef UART_PARITY_EN
    logic [10:0] pframe;
`endif

    addr  = 32'h0;
    wdata = 32'h0;
    wr    = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk_rd("rst_status", A_ST, 32'h2);
    chk_rd("rst_baud", A_BD, 32'd867);
    chk_rd("rst_ctrl", A_CT, 32'h0);
    chk_rd("txdata_read", A_TX, 32'h0);
    chk_rd("baud_lowbits_ignored", 32'h1100_010B, 32'd867);
    addr = 32'h1100_0110;
    #1;
    chk("miss_hit", {31'd0, rd_hit}, 32'd0);
    chk("miss_data", rd_data, 32'h0);

    // Frame shape and latency at 4 clocks per bit
    tick();
    wr_reg(A_BD, 32'd3);
    wr_reg(A_TX, 32'h55);
    addr = A_ST;
    chk("t1_tx_n0", {31'd0, tx}, 32'd1);
    tick();
    chk("t1_tx_n1", {31'd0, tx}, 32'd1);
    chk("t1_busy_n1", {31'd0, rd_data[2]}, 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("t1_bit%0d", i), {31'd0, tx}, {31'd0, frame[i / 4]});
      chk($sformatf("t1_busy%0d", i), {31'd0, rd_data[2]}, (i < 39) ? 32'd1 : 32'd0);
    end
    chk_rd("t1_status_after", A_ST, 32'h2);

    // Interrupt with 1 clock per bit
    do_reset();
    mon_p = 1;
    byte_q.delete();
    wr_reg(A_BD, 32'd0);
    wr_reg(A_CT, 32'd1);
    tick();
    chk("t2_intr_idle", {31'd0, intr}, 32'd1);
    wr_reg(A_TX, 32'hA5);
    chk("t2_intr_n0", {31'd0, intr}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t2_intr_n%0d", i), {31'd0, intr}, (i >= 12) ? 32'd1 : 32'd0);
    end
    chk("t2_rx_count", byte_q.size(), 32'd1);
    if (byte_q.size() > 0) chk("t2_rx_byte", {24'd0, byte_q[0]}, 32'hA5);
    wr_reg(A_CT, 32'd0);
    chk("t2_intr_hold", {31'd0, intr}, 32'd1);
    tick();
    chk("t2_intr_drop", {31'd0, intr}, 32'd0);

    // Overflow: 10 back-to-back pushes, one pop in between
    do_reset();
    wr_reg(A_BD, 32'd100);
    for (int i = 0; i < 10; i++) wr_reg(A_TX, 32'h30 + i);
    chk_rd("t3_status_ovf", A_ST, 32'h0000_080D);
    chk_rd("t3_txdata_read", A_TX, 32'h0);
    tick();
    wr_reg(A_ST, 32'h8);
    chk_rd("t3_status_clr", A_ST, 32'h0000_0805);

    // Push coinciding with pop while full
    do_reset();
    mon_p = 2;
    byte_q.delete();
    wr_reg(A_BD, 32'd1);
    wr_reg(A_TX, 32'h11);
    exp_b[0] = 8'h11;
    for (int i = 1; i <= 8; i++) begin
      wr_reg(A_TX, 32'h20 + i);
      exp_b[i] = 8'(8'h20 + i);
    end
    exp_b[9] = 8'h29;
    chk_rd("t4_full", A_ST, 32'h0000_0805);
    waited = 0;
    while (rd_data[2] && waited < 100) begin
      tick();
      waited++;
    end
    chk("t4_idle_wait", waited, 32'd13);
    wr_reg(A_TX, 32'h29);
    chk_rd("t4_full_after", A_ST, 32'h0000_0805);
    waited = 0;
    while (byte_q.size() < 10 && waited < 400) begin
      tick();
      waited++;
    end
    chk("t4_rx_count", byte_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < byte_q.size()) chk($sformatf("t4_rx%0d", i), {24'd0, byte_q[i]}, {24'd0, exp_b[i]});
    end

    // Reset during DATA bit 4
    do_reset();
    mon_p = 4;
    wr_reg(A_BD, 32'd3);
    wr_reg(A_TX, 32'h00);
    for (int i = 0; i < 23; i++) tick();
    chk("t5_tx_data4", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx_async", {31'd0, tx}, 32'd1);
    tick();
    rst_n = 1'b1;
    chk_rd("t5_status", A_ST, 32'h2);
    chk_rd("t5_baud", A_BD, 32'd867);
    chk("t5_intr", {31'd0, intr}, 32'd0);
    tick();
    chk("t5_tx_idle", {31'd0, tx}, 32'd1);

`ifdef UART_PARITY_EN
    do_reset();
    mon_p = 1;
    wr_reg(A_BD, 32'd0);
    wr_reg(A_CT, 32'h3);
    chk_rd("t6_ctrl", A_CT, 32'h3);
    wr_reg(A_TX, 32'h07);
    tick();
    pframe = {1'b1, 1'b1, 8'h07, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("t6_even%0d", i), {31'd0, tx}, {31'd0, pframe[i]});
    end
    tick();
    chk("t6_even_idle", {31'd0, tx}, 32'd1);
    wr_reg(A_CT, 32'h7);
    chk_rd("t6_ctrl_odd", A_CT, 32'h7);
    wr_reg(A_TX, 32'h07);
    tick();
    pframe = {1'b1, 1'b0, 8'h07, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("t6_odd%0d", i), {31'd0, tx}, {31'd0, pframe[i]});
    end
`else
    do_reset();
    wr_reg(A_CT, 32'h7);
    chk_rd("t6_ctrl_mask", A_CT, 32'h1);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
